// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch unit: FSM encoding, jump opcodes
// and the default reset vector.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } fetch_state_t;

  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [5:0]  OP_JAL           = 6'b000011;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: JR > jump/JAL > taken branch > pc+4,
// plus detection of a misaligned JR target.
module next_pc_sel (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] imm_field,
  input  logic        Branch,
  input  logic        BNE,
  input  logic        JALCtrl,
  input  logic        JumpReg,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic               br_taken;

  assign br_off    = signed'({{14{imm_field[15]}}, imm_field[15:0], 2'b00});
  assign br_target = pc_plus4 + $unsigned(br_off);
  // Branch and BNE together is illegal; the OR form simply takes either condition.
  assign br_taken  = (Branch & zero) | (BNE & ~zero);

  always_comb begin
    next_pc = pc_plus4;
    if (JumpReg)
      next_pc = {rs_data[31:2], 2'b00};
    else if (JALCtrl)
      next_pc = {pc_plus4[31:28], imm_field, 2'b00};
    else if (br_taken)
      next_pc = br_target;
  end

  assign misaligned = JumpReg & (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Multi-cycle PC/fetch unit: FETCH -> DECODE -> EXEC, committing the next PC
// when the datapath reports ex_done.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        Branch,
  input  logic        BNE,
  input  logic        JALCtrl,
  input  logic        JumpReg,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        ex_done,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        link_we,
  output logic        align_err
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         commit;

  assign pc_plus4 = pc + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pc_plus4   (pc_plus4),
    .imm_field  (instr[25:0]),
    .Branch     (Branch),
    .BNE        (BNE),
    .JALCtrl    (JALCtrl),
    .JumpReg    (JumpReg),
    .zero       (zero),
    .rs_data    (rs_data),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack)
        instr <= imem_rdata;
      if (commit)
        pc <= next_pc;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    commit      = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)
          state_nxt = DECODE;
      end
      DECODE: begin
        instr_valid = 1'b1;
        state_nxt   = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (ex_done) begin
          commit    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Strobes are qualified by ~rst so a reset on the commit edge aborts cleanly.
  assign link_we   = commit & ~rst & (instr[31:26] == OP_JAL);
  assign align_err = commit & ~rst & misaligned;

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign link_addr = pc_plus4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses are queued at
// each commit and compared when the unit next issues an instruction request.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] instr;
  logic        instr_valid;
  logic        Branch, BNE, JALCtrl, JumpReg, zero;
  logic [31:0] rs_data;
  logic        ex_done;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        link_we;
  logic        align_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          req_cyc = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .opcode(opcode), .funct(funct),
    .instr(instr), .instr_valid(instr_valid), .Branch(Branch), .BNE(BNE),
    .JALCtrl(JALCtrl), .JumpReg(JumpReg), .zero(zero), .rs_data(rs_data),
    .ex_done(ex_done), .pc(pc), .link_addr(link_addr), .link_we(link_we),
    .align_err(align_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic br, input logic bn, input logic jl, input logic jr,
                          input logic z, input logic [31:0] rs);
    Branch = br; BNE = bn; JALCtrl = jl; JumpReg = jr; zero = z; rs_data = rs;
  endtask

  // Control noise outside commit must be ignored by the unit.
  task automatic noise_ctrl();
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0F03);
  endtask

  task automatic wait_req_and_check(output logic [31:0] addr);
    int n = 0;
    logic [31:0] e;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
    req_cyc = cyc;
    addr = imem_addr;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("fetch_addr", imem_addr, e);
      chk("pc", pc, e);
    end
  endtask

  task automatic do_instr(input logic [31:0] word, input logic br, input logic bn,
                          input logic jl, input logic jr, input logic z,
                          input logic [31:0] rs, input int stall, input int exd,
                          input logic [31:0] exp_next, input logic exp_lw,
                          input logic exp_ae);
    logic [31:0] cur;
    wait_req_and_check(cur);
    noise_ctrl();
    ex_done = 1'b1;
    for (int k = 0; k < stall; k++) begin
      imem_ack = 1'b0;
      step();
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, cur);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("dec_valid", {31'd0, instr_valid}, 32'd1);
    chk("dec_req", {31'd0, imem_req}, 32'd0);
    chk("dec_instr", instr, word);
    chk("dec_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    chk("dec_funct", {26'd0, funct}, {26'd0, word[5:0]});
    chk("dec_strobes", {30'd0, link_we, align_err}, 32'd0);
    ex_done = 1'b0;
    step();
    for (int k = 0; k < exd; k++) begin
      chk("exec_wait_pc", pc, cur);
      step();
    end
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    set_ctrl(br, bn, jl, jr, z, rs);
    ex_done = 1'b1;
    #1;
    chk("commit_link_we", {31'd0, link_we}, {31'd0, exp_lw});
    chk("commit_align_err", {31'd0, align_err}, {31'd0, exp_ae});
    chk("link_addr", link_addr, cur + 32'd4);
    exp_q.push_back(exp_next);
    step();
    ex_done = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_strobes", {30'd0, link_we, align_err}, 32'd0);
    chk("post_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  localparam logic [31:0] W_ADD  = 32'h0022_0820;
  localparam logic [31:0] W_JR   = 32'h03E0_0008;
  localparam logic [31:0] W_JAL  = {6'b000011, 26'h10};
  localparam logic [31:0] W_J    = {6'b000010, 26'h20};

  initial begin
    logic [31:0] a;
    int t0, t1, t2;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; ex_done = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_strobes", {30'd0, link_we, align_err}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    exp_q.push_back(32'h0);

    // Sequential fetch with minimal spacing
    do_instr(W_ADD, 0,0,0,0,0, 0, 0, 0, 32'h4, 0, 0); t0 = req_cyc;
    do_instr(W_ADD, 0,0,0,0,0, 0, 0, 0, 32'h8, 0, 0); t1 = req_cyc;
    do_instr(W_ADD, 0,0,0,0,0, 0, 5, 2, 32'hC, 0, 0); t2 = req_cyc;
    chk("spacing_0_4", t1 - t0, 32'd3);
    chk("spacing_4_8", t2 - t1, 32'd3);

    // Branches around pc=0x100
    do_instr(W_JR, 0,0,0,1,0, 32'h100, 0, 0, 32'h100, 0, 0);
    do_instr({6'b000100, 10'd0, 16'hFFFE}, 1,0,0,0,1, 0, 0, 0, 32'hFC, 0, 0);
    do_instr(W_JR, 0,0,0,1,0, 32'h100, 0, 0, 32'h100, 0, 0);
    do_instr({6'b000101, 10'd0, 16'h0003}, 0,1,0,0,1, 0, 0, 0, 32'h104, 0, 0);
    do_instr(W_JR, 0,0,0,1,0, 32'h100, 0, 0, 32'h100, 0, 0);
    do_instr({6'b000101, 10'd0, 16'h0003}, 0,1,0,0,0, 0, 1, 0, 32'h110, 0, 0);
    do_instr({6'b000100, 10'd0, 16'h0001}, 1,1,0,0,1, 0, 0, 0, 32'h118, 0, 0);

    // JAL and J
    do_instr(W_JR, 0,0,0,1,0, 32'h0040_0000, 0, 0, 32'h0040_0000, 0, 0);
    do_instr(W_JAL, 0,0,1,0,0, 0, 0, 1, 32'h0000_0040, 1, 0);
    do_instr(W_J, 0,0,1,0,0, 0, 0, 0, 32'h0000_0080, 0, 0);

    // JR misaligned and JR over JAL priority
    do_instr(W_JR, 0,0,0,1,0, 32'h203, 0, 0, 32'h200, 0, 1);
    do_instr(W_JR, 0,0,1,1,0, 32'h300, 0, 0, 32'h300, 0, 0);

    // Reset mid-FETCH with an ack in the reset cycle
    wait_req_and_check(a);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    rst = 1'b0; imem_ack = 1'b0;
    chk("rstf_instr", instr, 32'h0);
    chk("rstf_pc", pc, 32'h0);
    chk("rstf_valid", {31'd0, instr_valid}, 32'd0);
    exp_q.delete();
    exp_q.push_back(32'h0);
    do_instr(W_ADD, 0,0,0,0,0, 0, 0, 0, 32'h4, 0, 0);

    // Reset mid-EXEC on a JAL commit attempt
    wait_req_and_check(a);
    imem_ack = 1'b1; imem_rdata = W_JAL;
    step();
    imem_ack = 1'b0;
    step();
    set_ctrl(0,0,1,0,0,0);
    ex_done = 1'b1; rst = 1'b1;
    #1;
    chk("rste_link_we", {31'd0, link_we}, 32'd0);
    step();
    rst = 1'b0; ex_done = 1'b0;
    set_ctrl(0,0,0,0,0,0);
    chk("rste_pc", pc, 32'h0);
    chk("rste_req", {31'd0, imem_req}, 32'd1);
    chk("rste_instr", instr, 32'h0);
    exp_q.delete();
    exp_q.push_back(32'h0);

    // PC wrap-around
    do_instr(W_JR, 0,0,0,1,0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0);
    do_instr(W_ADD, 0,0,0,0,0, 0, 0, 0, 32'h0, 0, 0);
    wait_req_and_check(a);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  instruction-memory word address; equals pc.
- imem_ack  in  1  memory has returned the instruction word.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- opcode  out  6  instr[31:26], driven to main control.
- funct  out  6  instr[5:0], driven to main control.
- instr  out  32  held instruction register.
- instr_valid  out  1  high while instr is held for decode/execute.
- Branch, BNE, JALCtrl, JumpReg  in  1 each  decoded control from main control.
- zero  in  1  ALU zero flag.
- rs_data  in  32  register-file rs read value, used for JR.
- ex_done  in  1  datapath has completed the current instruction.
- pc  out  32  current PC.
- link_addr  out  32  pc+4, the JAL return address.
- link_we  out  1  one-cycle write strobe for $31 on JAL commit.
- align_err  out  1  one-cycle pulse on misaligned JR target.

Function
REQ-003 SHALL implement FSM states FETCH, DECODE, EXEC.
REQ-004 In FETCH, imem_req SHALL be 1; on imem_ack=1, the unit SHALL latch imem_rdata into instr and go to DECODE; otherwise it SHALL stay in FETCH, holding imem_req and imem_addr stable.
REQ-005 DECODE SHALL last exactly one cycle, then go to EXEC; imem_req SHALL be 0 in DECODE and EXEC.
REQ-006 instr_valid SHALL be 1 in DECODE and EXEC only; opcode/funct SHALL be taken from the instr register, never directly from imem_rdata.
REQ-007 In EXEC, when ex_done=1 the unit SHALL commit: load pc with next_pc and go to FETCH; otherwise it SHALL stay in EXEC with pc and instr unchanged.
REQ-008 pc+4 SHALL be computed modulo 2^32; wrap-around from 32'hFFFF_FFFC to 0 is legal.
REQ-009 next_pc priority, evaluated at commit:
- JumpReg=1 -> {rs_data[31:2],2'b00}.
- else JALCtrl=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}.
- else (Branch&zero)|(BNE&~zero) -> pc_plus4 + (sign-extended instr[15:0] << 2), modulo 2^32.
- else pc_plus4.
REQ-010 If JumpReg=1 and rs_data[1:0]!=0 at commit, align_err SHALL pulse for that one cycle; the target SHALL still be rs_data with bits [1:0] forced to 0.
REQ-011 link_we SHALL pulse for exactly the commit cycle when instr[31:26]=6'b000011 (JAL); J SHALL NOT assert it.
REQ-012 link_addr SHALL equal pc+4 continuously.
REQ-013 Branch and BNE both 1 is illegal; the unit SHALL then take the branch if the OR expression in REQ-009 is true.
REQ-014 Minimum instruction period SHALL be 3 cycles: ack in FETCH, DECODE, ex_done in EXEC.
REQ-015 Control inputs SHALL be sampled only at commit; values in other states SHALL be ignored.

Reset
REQ-016 With rst=1 at a clock edge: pc=RESET_PC, instr=0, state=FETCH, link_we=0, align_err=0.
REQ-017 In the cycle after rst deasserts, imem_req SHALL be 1 and imem_addr SHALL be RESET_PC.
REQ-018 Reset in any state, including mid-FETCH with an outstanding request or mid-EXEC, SHALL abort the instruction with no PC commit and no link_we; an imem_ack in the reset cycle SHALL be ignored.

Structure
REQ-019 The following SHALL live in the shared CPU package: FSM state encoding; opcode constants OP_J=6'b000010 and OP_JAL=6'b000011; RESET_PC default.
REQ-020 The unit SHALL contain one sub-module, next_pc_sel, which is purely combinational and implements REQ-009 and REQ-010; the FSM and registers SHALL stay in pc_fetch_unit.

Verification
REQ-021 Reset then sequential fetch:
- rst, then ack each FETCH, ex_done each EXEC, no control -> imem_addr 0,4,8 with 3-cycle spacing.
REQ-022 Memory stall:
- imem_ack held 0 for 5 cycles -> imem_req=1 and imem_addr unchanged throughout; DECODE entered the cycle after ack.
REQ-023 Branches at pc=0x100:
- BEQ, zero=1, imm=16'hFFFE -> next pc 0xFC.
- BNE, zero=1 -> next pc 0x104.
- BNE, zero=0, imm=3 -> next pc 0x110.
REQ-024 JAL at pc=0x0040_0000, instr[25:0]=26'h10 -> next pc 0x0000_0040; link_we pulses once; link_addr=0x0040_0004.
REQ-025 JR misaligned and JR+JAL priority:
- JumpReg=1, rs_data=0x203 -> next pc 0x200, align_err single pulse.
- JumpReg=1 and JALCtrl=1 together -> rs_data path wins.
REQ-026 Wrap and reset mid-EXEC:
- pc=0xFFFF_FFFC, sequential commit -> pc=0.
- rst asserted in EXEC -> pc=RESET_PC, no link_we, FETCH the next cycle.
